uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx_pkg.sv | 17 +
 rtl/uart_tx_hold.sv | 32 +++
 rtl/uart_tx.sv | 128 ++++++++++++
 tb/tb_uart_tx.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: FSM state encodings and word geometry,
// imported by both the transmitter and the receiver.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_STOP    = 3'd3,
        ST_CLEANUP = 3'd4
    } tx_state_t;

    localparam int WORD_W = 32;
    localparam int IDX_W  = $clog2(WORD_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

endpackage

// File: rtl/uart_tx_hold.sv
// One-entry holding buffer: a valid flag plus a word register, loaded on
// accept and cleared when the transmitter takes the word.
module uart_tx_hold
    import uart_tx_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [WORD_W-1:0] data,
    output logic              valid,
    output logic [WORD_W-1:0] word
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

    // The word register carries no reset; only the flag says whether it means anything.
    always_ff @(posedge clk) begin
        if (load) begin
            word <= data;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 32-bit word UART transmitter: start bit, 32 data bits LSB first, stop bit,
// with a one-entry holding buffer so the next word can queue during a frame.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    input  logic              i_Tx_DV,
    input  logic [WORD_W-1:0] i_Tx_Word,
    output logic              o_Tx_Ready,
    output logic              o_Tx_Serial,
    output logic              o_Tx_Active,
    output logic              o_Tx_Done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_t         state;
    tx_state_t         state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_next;
    logic [WORD_W-1:0] shift;
    logic              hold_valid;
    logic [WORD_W-1:0] hold_word;
    logic              bit_end;
    logic              take;
    logic              load;
    logic              serial_d;

    assign bit_end    = (cnt == CNT_LAST);
    assign take       = (state == ST_IDLE) && hold_valid;
    assign load       = i_Tx_DV && !hold_valid;
    assign o_Tx_Ready = !hold_valid;

    uart_tx_hold u_hold (
        .clk   (i_Clock),
        .rst   (i_Reset),
        .load  (load),
        .clear (take),
        .data  (i_Tx_Word),
        .valid (hold_valid),
        .word  (hold_word)
    );

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            idx         <= '0;
            o_Tx_Serial <= 1'b1;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            idx         <= idx_next;
            o_Tx_Serial <= serial_d;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (take) begin
            shift <= hold_word;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idx_next   = idx;
        case (state)
            ST_IDLE: begin
                cnt_next = '0;
                idx_next = '0;
                if (hold_valid) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                cnt_next = bit_end ? '0 : cnt + CNT_W'(1);
                if (bit_end) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                cnt_next = bit_end ? '0 : cnt + CNT_W'(1);
                if (bit_end) begin
                    // Index wraps from 31 back to 0 on its own.
                    idx_next = idx + IDX_W'(1);
                    if (idx == LAST_IDX) begin
                        state_next = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                cnt_next = bit_end ? '0 : cnt + CNT_W'(1);
                if (bit_end) begin
                    state_next = ST_CLEANUP;
                end
            end
            ST_CLEANUP: begin
                cnt_next   = '0;
                state_next = ST_IDLE;
            end
            default: begin
                cnt_next   = '0;
                idx_next   = '0;
                state_next = ST_IDLE;
            end
        endcase
    end

    // The line is registered from the next state so it changes with the state itself.
    always_comb begin
        serial_d = 1'b1;
        case (state_next)
            ST_START: serial_d = 1'b0;
            ST_DATA:  serial_d = shift[idx_next];
            default:  serial_d = 1'b1;
        endcase
        o_Tx_Active = (state == ST_START) || (state == ST_DATA) || (state == ST_STOP);
        o_Tx_Done   = (state == ST_CLEANUP);
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: frame-level line model, behavioural receiver, directed
// literal checks and a randomized stream of words.
module tb_uart_tx;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        i_Reset;
    logic        i_Tx_DV;
    logic [31:0] i_Tx_Word;
    logic        o_Tx_Ready;
    logic        o_Tx_Serial;
    logic        o_Tx_Active;
    logic        o_Tx_Done;

    uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clock     (clk),
        .i_Reset     (i_Reset),
        .i_Tx_DV     (i_Tx_DV),
        .i_Tx_Word   (i_Tx_Word),
        .o_Tx_Ready  (o_Tx_Ready),
        .o_Tx_Serial (o_Tx_Serial),
        .o_Tx_Active (o_Tx_Active),
        .o_Tx_Done   (o_Tx_Done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Line model: each accepted frame expands to its per-cycle {serial, active, done}.
    logic [2:0]  q[$];
    logic [31:0] frame_words[$];
    logic        mvalid = 1'b0;
    logic [31:0] mword;
    logic        exp_serial = 1'b1;
    logic        exp_active = 1'b0;
    logic        exp_done   = 1'b0;
    logic        exp_ready  = 1'b1;
    int          frames_done = 0;
    int          rx_count = 0;
    bit          rx_kill = 1'b0;
    bit          cmp_en = 1'b0;

    task automatic push_frame(input logic [31:0] w);
        for (int b = 0; b < 34; b++) begin
            logic bitv;
            bitv = (b == 0) ? 1'b0 : (b == 33) ? 1'b1 : w[b-1];
            repeat (CPB) q.push_back({bitv, 1'b1, 1'b0});
        end
        q.push_back(3'b101);
        q.push_back(3'b100);
    endtask

    always @(posedge clk) begin : line_model
        logic [2:0] e;
        logic       old;
        if (i_Reset) begin
            q.delete();
            frame_words.delete();
            mvalid  = 1'b0;
            rx_kill = 1'b1;
        end else begin
            old = mvalid;
            if (q.size() == 0 && old) begin
                push_frame(mword);
                frame_words.push_back(mword);
                mvalid = 1'b0;
            end
            if (i_Tx_DV && !old) begin
                mvalid = 1'b1;
                mword  = i_Tx_Word;
            end
        end
        e = (q.size() > 0) ? q.pop_front() : 3'b100;
        if (e[0]) frames_done++;
        exp_serial = e[2];
        exp_active = e[1];
        exp_done   = e[0];
        exp_ready  = !mvalid;
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check1("serial", o_Tx_Serial, exp_serial);
            check1("active", o_Tx_Active, exp_active);
            check1("done",   o_Tx_Done,   exp_done);
            check1("ready",  o_Tx_Ready,  exp_ready);
        end
    end

    // Receiver: finds the start edge and samples each bit in its middle.
    bit          rx_busy = 1'b0;
    int          rx_t = 0;
    logic [31:0] rx_word;

    always @(negedge clk) begin : rx_model
        int k;
        if (rx_kill) begin
            rx_busy = 1'b0;
            rx_kill = 1'b0;
        end else if (cmp_en) begin
            if (!rx_busy) begin
                if (o_Tx_Serial == 1'b0) begin
                    rx_busy = 1'b1;
                    rx_t    = 0;
                end
            end else begin
                rx_t++;
            end
            if (rx_busy && (rx_t % CPB) == CPB / 2) begin
                k = rx_t / CPB;
                if (k == 0) begin
                    check1("rx_start", o_Tx_Serial, 1'b0);
                end else if (k <= 32) begin
                    rx_word[k-1] = o_Tx_Serial;
                end else begin
                    check1("rx_stop", o_Tx_Serial, 1'b1);
                    if (frame_words.size() > 0) begin
                        check32("rx_word", rx_word, frame_words.pop_front());
                    end else begin
                        checks++;
                        $display("FAIL rx_unexpected: got word %h expected no frame", rx_word);
                    end
                    rx_count++;
                    rx_busy = 1'b0;
                end
            end
        end
    end

    logic ser[0:399];
    logic rdy[0:399];
    logic act[0:399];
    logic dn[0:399];

    // Accept w0 on edge 0, optional DV pulses landing on edges a1/a2, optional reset edge r.
    task automatic capture(input int n, input logic [31:0] w0,
                           input int a1, input logic [31:0] w1,
                           input int a2, input logic [31:0] w2, input int r);
        @(negedge clk);
        i_Tx_DV   = 1'b1;
        i_Tx_Word = w0;
        for (int k = 0; k <= n; k++) begin
            @(negedge clk);
            ser[k] = o_Tx_Serial;
            rdy[k] = o_Tx_Ready;
            act[k] = o_Tx_Active;
            dn[k]  = o_Tx_Done;
            i_Tx_DV   = 1'b0;
            i_Reset   = 1'b0;
            i_Tx_Word = $urandom;
            if (k == a1 - 1) begin i_Tx_DV = 1'b1; i_Tx_Word = w1; end
            if (k == a2 - 1) begin i_Tx_DV = 1'b1; i_Tx_Word = w2; end
            if (k == r - 1) i_Reset = 1'b1;
        end
        i_Tx_DV = 1'b0;
        i_Reset = 1'b0;
    endtask

    initial begin
        int base;
        int cyc;
        int bad;
        i_Reset   = 1'b1;
        i_Tx_DV   = 1'b0;
        i_Tx_Word = '0;
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        check1("rst_serial", o_Tx_Serial, 1'b1);
        check1("rst_ready",  o_Tx_Ready,  1'b1);
        check1("rst_active", o_Tx_Active, 1'b0);
        check1("rst_done",   o_Tx_Done,   1'b0);
        i_Tx_DV   = 1'b1;
        i_Tx_Word = 32'hFFFF_0000;
        @(negedge clk);
        i_Reset = 1'b0;
        i_Tx_DV = 1'b0;
        repeat (3) @(negedge clk);
        check1("dv_in_reset_ignored", o_Tx_Active, 1'b0);

        // Single word 0xA5A50F01
        capture(145, 32'hA5A5_0F01, -10, '0, -10, '0, -10);
        check1("w1_ready_c0",  rdy[0],   1'b0);
        check1("w1_ready_c1",  rdy[1],   1'b1);
        check1("w1_start_c1",  ser[1],   1'b0);
        check1("w1_start_c4",  ser[4],   1'b0);
        check1("w1_bit0",      ser[5],   1'b1);
        check1("w1_bit1",      ser[9],   1'b0);
        check1("w1_bit8",      ser[37],  1'b1);
        check1("w1_bit12",     ser[53],  1'b0);
        check1("w1_bit30",     ser[128], 1'b0);
        check1("w1_bit31",     ser[132], 1'b1);
        check1("w1_stop",      ser[133], 1'b1);
        check1("w1_active",    act[136], 1'b1);
        check1("w1_done_136",  dn[136],  1'b0);
        check1("w1_done_137",  dn[137],  1'b1);
        check1("w1_done_138",  dn[138],  1'b0);
        check1("w1_active_137", act[137], 1'b0);
        repeat (5) @(negedge clk);

        // Back-to-back plus a dropped request
        capture(300, 32'h0000_0000, 10, 32'hFFFF_FFFF, 20, 32'hDEAD_BEEF, -10);
        check1("b2b_bit31_first", ser[132], 1'b0);
        check1("b2b_gap_133",     ser[133], 1'b1);
        check1("b2b_gap_138",     ser[138], 1'b1);
        check1("b2b_start2",      ser[139], 1'b0);
        check1("b2b_start2_end",  ser[142], 1'b0);
        check1("b2b_bit0_second", ser[143], 1'b1);
        check1("b2b_ready_138",   rdy[138], 1'b0);
        check1("b2b_ready_139",   rdy[139], 1'b1);
        check1("b2b_done1",       dn[137],  1'b1);
        check1("b2b_done2",       dn[275],  1'b1);
        check1("drop_no_frame",   ser[277], 1'b0 == 1'b1 ? 1'b0 : 1'b1);
        check1("drop_idle",       act[280], 1'b0);
        repeat (5) @(negedge clk);

        // Reset during bit 10 with a word waiting in the buffer
        capture(300, 32'h1234_5678, 5, 32'hCAFE_F00D, -10, '0, 46);
        check1("rst_ready_c4",  rdy[4],  1'b1);
        check1("rst_ready_c5",  rdy[5],  1'b0);
        check1("rst_bit8",      ser[40], 1'b0);
        check1("rst_bit10",     ser[45], 1'b1);
        check1("rst_ready_c45", rdy[45], 1'b0);
        check1("rst_line_high", ser[46], 1'b1);
        check1("rst_inactive",  act[46], 1'b0);
        check1("rst_ready_c46", rdy[46], 1'b1);
        check1("rst_no_bit11",  ser[49], 1'b1);
        bad = 0;
        for (int k = 47; k <= 300; k++)
            if (ser[k] !== 1'b1 || dn[k] !== 1'b0 || act[k] !== 1'b0) bad++;
        check32("rst_no_frame_after", 32'(bad), 32'd0);

        // Randomized stream of 100 frames
        base = rx_count;
        cyc  = 0;
        while (rx_count < base + 100 && cyc < 40000) begin
            @(negedge clk);
            i_Tx_DV   = ($urandom_range(0, 5) == 0);
            i_Tx_Word = $urandom;
            i_Reset   = (q.size() > 8) && ($urandom_range(0, 2999) == 0);
            cyc++;
        end
        i_Tx_DV = 1'b0;
        i_Reset = 1'b0;
        check1("random_frames_within_budget", rx_count >= base + 100, 1'b1);
        cyc = 0;
        while ((q.size() != 0 || mvalid) && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        repeat (10) @(negedge clk);
        check32("words_left", 32'(frame_words.size()), 32'd0);
        check32("rx_vs_frames", 32'(rx_count), 32'(frames_done));
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
